affine_sequencer: RTL and testbench
===================================

// Module: affine_sequencer
// PURPOSE
//  Multi-cycle controller that time-shares the single combinational alu to compute a 2-D affine map:
//  x' = c11*x + c12*y + b1, y' = c21*x + c22*y + b2. It drives alu a/b/func, captures alu result
//  into internal temporaries, and signals completion through a start/busy/done handshake.
//  It sits beside the picoMIPS datapath as an accelerator and drives the alu when the core mux grants it.
// PARAMETERS
//  N       cpuConfig::N (8)  data width; coefficients are signed Q1.(N-1), x/y/b are signed integers
// PORTS
//  clk       in   1        system clock, rising edge
//  reset     in   1        asynchronous, active-high reset
//  start     in   1        request a transform; sampled only in IDLE
//  x_in,y_in in   N        input point, latched on accepted start
//  c11,c12,c21,c22 in N    fixed-point coefficients, latched on accepted start
//  b1,b2     in   N        integer offsets, latched on accepted start
//  alu_result in  N        combinational result from alu
//  alu_a,alu_b out N       alu operands (registered)
//  alu_func  out  aluFunc_t alu operation (registered)
//  busy      out  1        sequence in progress
//  done      out  1        one-cycle pulse: x_out/y_out just updated
//  x_out,y_out out N       results; hold until next done
// BEHAVIOUR
//  - Reset (any time, including mid-sequence): state=IDLE, all outputs 0, alu_func=ALU_A; done is not pulsed.
//  - States: IDLE, MX1, MX2, AX1, AX2, MY1, MY2, AY1, AY2. Each compute state lasts exactly 1 cycle.
//    On each compute edge, alu_result is written to the destination named below.
//    MX1 MUL c11,x->t0 | MX2 MUL c12,y->t1 | AX1 ADD t0,t1->t0 | AX2 ADD t0,b1->x_out
//    MY1 MUL c21,x->t0 | MY2 MUL c22,y->t1 | AY1 ADD t0,t1->t0 | AY2 ADD t0,b2->y_out
//  - alu_a/alu_b/alu_func are registered with the state, so each ALU operation spans one full cycle.
//  - MUL: a = Q1.(N-1) coefficient, b = integer. The result is the integer floor of a*b
//    (0.75*6=4; -0.5*5=-3). ADD wraps modulo 2^N unless AFFINE_SAT_EN is defined.
//  - start in IDLE: operands latched on that edge, next state MX1, busy=1 from the next cycle.
//  - Latency: the start edge is followed by 8 compute cycles. At the AY2 edge: x_out/y_out valid,
//    done=1 for one cycle, busy=0, state=IDLE.
//  - x_out updates at the AX2 edge (internal register). The visible x_out/y_out pair both change
//    only at the done edge.
//  - start while busy: ignored, and input ports may change freely.
//  - start held high through done: a new sequence is accepted on the first IDLE cycle, giving
//    back-to-back throughput of 1 per 9 cycles.
//  - In IDLE: alu_a=alu_b=0, alu_func=ALU_A.
// CONFIGURATION
//  AFFINE_SAT_EN defined:
//    - Each ADD step checks signed overflow (operands same sign, result sign differs).
//    - On overflow the captured value clamps to +2^(N-1)-1 or -2^(N-1).
//    - The overflow flag sticks; sat_flag out (1 bit) goes high at done if any ADD clamped, and is
//      cleared at the next accepted start.
//  AFFINE_SAT_EN undefined: ADD results wrap; the sat_flag port does not exist.
// TESTING
//  1 reset, idle 3 cycles -> busy=0, done=0, x_out=y_out=0, alu_func=ALU_A
//  2 x=6,y=5,c11=0x60,c12=0x00,b1=3,c21=0x40,c22=0xC0,b2=2, start 1 cycle
//    -> done exactly 9 cycles after start edge; x_out=7, y_out=2 (0x02); busy high 8 cycles
//  3 x=y=127, c11=c12=0x7F, b1=0 -> x_out=0xFC (wrap); with AFFINE_SAT_EN x_out=0x7F, sat_flag=1
//  4 start pulsed again at cycle 3 of a sequence with changed x_in
//    -> ignored; results match the original operands; one done only
//  5 assert reset at cycle 5 of a sequence -> immediate IDLE, outputs 0, no done; a fresh start
//    then completes correctly
//  6 start held high for 20 cycles -> done pulses at cycles 9 and 18; busy low only on done cycles

Source files
------------

// File: rtl/affine_sequencer.sv
// affine_sequencer: time-shares one combinational ALU to compute
//   x' = c11*x + c12*y + b1,  y' = c21*x + c22*y + b2
// Coefficients are signed Q1.(N-1); x, y, b are signed integers.
// Optional build macro AFFINE_SAT_EN: saturating ADD steps plus a sticky sat_flag output.
// ALU function encoding: ALU_A = 0 (pass a), ALU_ADD = 1, ALU_MUL = 2.
//
// state | meaning
// IDLE  | waiting for start, ALU driven with pass-through of 0
// MX1   | MUL c11*x -> t0
// MX2   | MUL c12*y -> t1 (forwarded straight into the AX1 operand)
// AX1   | ADD t0+t1 -> t0
// AX2   | ADD t0+b1 -> internal x result
// MY1   | MUL c21*x -> t0
// MY2   | MUL c22*y -> t1 (forwarded straight into the AY1 operand)
// AY1   | ADD t0+t1 -> t0
// AY2   | ADD t0+b2 -> y_out, publish x_out, pulse done
module affine_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] y_in,
    input  logic [N-1:0] c11,
    input  logic [N-1:0] c12,
    input  logic [N-1:0] c21,
    input  logic [N-1:0] c22,
    input  logic [N-1:0] b1,
    input  logic [N-1:0] b2,
    input  logic [N-1:0] alu_result,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_func,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] x_out,
    output logic [N-1:0] y_out
`ifdef AFFINE_SAT_EN
    ,
    output logic         sat_flag
`endif
);

    localparam logic [2:0] ALU_A   = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;

    typedef enum logic [3:0] {
        IDLE, MX1, MX2, AX1, AX2, MY1, MY2, AY1, AY2
    } state_t;

    state_t       state_q;
    logic [N-1:0] x_q, y_q, c12_q, c21_q, c22_q, b1_q, b2_q;
    logic [N-1:0] t0_q, x_int_q;
    logic [N-1:0] alu_a_q, alu_b_q;
    logic [2:0]   alu_func_q;
    logic         busy_q, done_q;
    logic [N-1:0] x_out_q, y_out_q;
    logic [N-1:0] add_res_d;
`ifdef AFFINE_SAT_EN
    logic         ovf_d;
    logic         sat_acc_q, sat_flag_q;
`endif

    // ADD-step result as captured: plain wrap, or clamped on signed overflow
    always_comb begin
        add_res_d = alu_result;
`ifdef AFFINE_SAT_EN
        ovf_d = (alu_a_q[N-1] == alu_b_q[N-1]) && (alu_result[N-1] != alu_a_q[N-1]);
        if (ovf_d) begin
            add_res_d = alu_a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    // Sequencer FSM; ALU operands are set up one edge ahead of the state that uses them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            c12_q      <= '0;
            c21_q      <= '0;
            c22_q      <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            t0_q       <= '0;
            x_int_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_func_q <= ALU_A;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            x_out_q    <= '0;
            y_out_q    <= '0;
`ifdef AFFINE_SAT_EN
            sat_acc_q  <= 1'b0;
            sat_flag_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q        <= x_in;
                        y_q        <= y_in;
                        c12_q      <= c12;
                        c21_q      <= c21;
                        c22_q      <= c22;
                        b1_q       <= b1;
                        b2_q       <= b2;
                        alu_a_q    <= c11;
                        alu_b_q    <= x_in;
                        alu_func_q <= ALU_MUL;
                        busy_q     <= 1'b1;
                        state_q    <= MX1;
`ifdef AFFINE_SAT_EN
                        sat_acc_q  <= 1'b0;
                        sat_flag_q <= 1'b0;
`endif
                    end else begin
                        alu_a_q    <= '0;
                        alu_b_q    <= '0;
                        alu_func_q <= ALU_A;
                    end
                end
                MX1: begin
                    t0_q       <= alu_result;
                    alu_a_q    <= c12_q;
                    alu_b_q    <= y_q;
                    alu_func_q <= ALU_MUL;
                    state_q    <= MX2;
                end
                MX2: begin
                    alu_a_q    <= t0_q;
                    alu_b_q    <= alu_result;
                    alu_func_q <= ALU_ADD;
                    state_q    <= AX1;
                end
                AX1: begin
                    t0_q       <= add_res_d;
                    alu_a_q    <= add_res_d;
                    alu_b_q    <= b1_q;
                    alu_func_q <= ALU_ADD;
                    state_q    <= AX2;
`ifdef AFFINE_SAT_EN
                    sat_acc_q  <= sat_acc_q | ovf_d;
`endif
                end
                AX2: begin
                    x_int_q    <= add_res_d;
                    alu_a_q    <= c21_q;
                    alu_b_q    <= x_q;
                    alu_func_q <= ALU_MUL;
                    state_q    <= MY1;
`ifdef AFFINE_SAT_EN
                    sat_acc_q  <= sat_acc_q | ovf_d;
`endif
                end
                MY1: begin
                    t0_q       <= alu_result;
                    alu_a_q    <= c22_q;
                    alu_b_q    <= y_q;
                    alu_func_q <= ALU_MUL;
                    state_q    <= MY2;
                end
                MY2: begin
                    alu_a_q    <= t0_q;
                    alu_b_q    <= alu_result;
                    alu_func_q <= ALU_ADD;
                    state_q    <= AY1;
                end
                AY1: begin
                    t0_q       <= add_res_d;
                    alu_a_q    <= add_res_d;
                    alu_b_q    <= b2_q;
                    alu_func_q <= ALU_ADD;
                    state_q    <= AY2;
`ifdef AFFINE_SAT_EN
                    sat_acc_q  <= sat_acc_q | ovf_d;
`endif
                end
                AY2: begin
                    x_out_q    <= x_int_q;
                    y_out_q    <= add_res_d;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    alu_a_q    <= '0;
                    alu_b_q    <= '0;
                    alu_func_q <= ALU_A;
                    state_q    <= IDLE;
`ifdef AFFINE_SAT_EN
                    sat_flag_q <= sat_acc_q | ovf_d;
`endif
                end
                default: begin
                    alu_a_q    <= '0;
                    alu_b_q    <= '0;
                    alu_func_q <= ALU_A;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_func = alu_func_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign x_out    = x_out_q;
    assign y_out    = y_out_q;
`ifdef AFFINE_SAT_EN
    assign sat_flag = sat_flag_q;
`endif

endmodule

// File: tb/tb_affine_sequencer.sv
// Scoreboard bench for affine_sequencer with a behavioural ALU model.
module tb_affine_sequencer;
    localparam int N = 8;
    localparam logic [2:0] ALU_A   = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [N-1:0] x_in = '0, y_in = '0, c11 = '0, c12 = '0, c21 = '0, c22 = '0, b1 = '0, b2 = '0;
    logic [N-1:0] alu_result, alu_a, alu_b, x_out, y_out;
    logic [2:0]   alu_func;
    logic         busy, done;
`ifdef AFFINE_SAT_EN
    logic         sat_flag;
    localparam logic SAT_BUILD = 1'b1;
`else
    localparam logic SAT_BUILD = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic         sat;
        int           edge_n;
    } exp_t;
    exp_t q[$];

    affine_sequencer #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x_in(x_in), .y_in(y_in),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .b1(b1), .b2(b2),
        .alu_result(alu_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .busy(busy), .done(done),
        .x_out(x_out), .y_out(y_out)
`ifdef AFFINE_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: MUL is floor(Q1.7 * int) via arithmetic shift, ADD wraps
    logic signed [2*N-1:0] prod;
    always_comb begin
        prod = $signed(alu_a) * $signed(alu_b);
        case (alu_func)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_MUL: alu_result = prod[2*N-2:N-1];
            default: alu_result = alu_a;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [N-1:0] ex, input logic [N-1:0] ey, input logic es,
                            input int edge_n);
        exp_t e;
        e.x = ex;
        e.y = ey;
        e.sat = es;
        e.edge_n = edge_n;
        q.push_back(e);
    endtask

    task automatic set_ops(input logic [N-1:0] x, input logic [N-1:0] y,
                           input logic [N-1:0] k11, input logic [N-1:0] k12,
                           input logic [N-1:0] k21, input logic [N-1:0] k22,
                           input logic [N-1:0] o1, input logic [N-1:0] o2);
        x_in = x; y_in = y; c11 = k11; c12 = k12; c21 = k21; c22 = k22; b1 = o1; b2 = o2;
    endtask

    // One-cycle start; done expected on the 8th edge after the start edge
    task automatic issue(input logic [N-1:0] ex, input logic [N-1:0] ey, input logic es);
        start = 1'b1;
        push_exp(ex, ey, es, cyc + 9);
        tick();
        start = 1'b0;
    endtask

    // Monitor: every done pops one expected result
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done required=no_done (cyc %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("x_out", 32'(x_out), 32'(e.x));
                chk("y_out", 32'(y_out), 32'(e.y));
                chk("done_edge", cyc, e.edge_n);
`ifdef AFFINE_SAT_EN
                chk("sat_flag", 32'(sat_flag), 32'(e.sat));
`endif
            end
        end
    end

    initial begin
        int bc;
        int n;
        logic [N-1:0] ex3;
        // 1: reset then idle
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_x_out", 32'(x_out), 0);
        chk("rst_y_out", 32'(y_out), 0);
        chk("rst_alu_func", 32'(alu_func), 32'(ALU_A));

        // 2: x'=0.75*6+0*5+3=7, y'=0.5*6-0.5*5+2 = 3-3+2 = 2
        set_ops(8'd6, 8'd5, 8'h60, 8'h00, 8'h40, 8'hC0, 8'd3, 8'd2);
        issue(8'd7, 8'd2, 1'b0);
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) bc++;
            tick();
        end
        chk("busy_cycles", bc, 8);
        chk("idle_alu_func", 32'(alu_func), 32'(ALU_A));
        chk("idle_alu_a", 32'(alu_a), 0);
        chk("idle_alu_b", 32'(alu_b), 0);

        // 3: 126+126 overflows: wraps to 0xFC, or clamps to 0x7F
        ex3 = SAT_BUILD ? 8'h7F : 8'hFC;
        set_ops(8'd127, 8'd127, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'd0, 8'd0);
        issue(ex3, 8'd0, 1'b1);
        repeat (12) tick();

        // 4: x'=5-1-1=3, y'=-3-4+5=-2; mid-sequence start with new x_in ignored
        set_ops(8'd10, 8'hFC, 8'h40, 8'h20, 8'hE0, 8'h7F, 8'hFF, 8'd5);
        issue(8'd3, 8'hFE, 1'b0);
        repeat (2) tick();
        start = 1'b1;
        x_in = 8'd100;
        y_in = 8'd0;
        tick();
        start = 1'b0;
        repeat (12) tick();

        // 5: reset mid-sequence, then a fresh transform
        set_ops(8'd6, 8'd5, 8'h60, 8'h00, 8'h40, 8'hC0, 8'd3, 8'd2);
        issue(8'd7, 8'd2, 1'b0);
        repeat (4) tick();
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_x_out", 32'(x_out), 0);
        chk("midrst_y_out", 32'(y_out), 0);
        chk("midrst_alu_func", 32'(alu_func), 32'(ALU_A));
        q.delete();
        tick();
        reset = 1'b0;
        repeat (12) tick();
        issue(8'd7, 8'd2, 1'b0);
        repeat (12) tick();

        // 6: start held 20 cycles: accepts at edges s, s+9, s+18
        set_ops(8'd10, 8'hFC, 8'h40, 8'h20, 8'hE0, 8'h7F, 8'hFF, 8'd5);
        start = 1'b1;
        push_exp(8'd3, 8'hFE, 1'b0, cyc + 9);
        push_exp(8'd3, 8'hFE, 1'b0, cyc + 18);
        push_exp(8'd3, 8'hFE, 1'b0, cyc + 27);
        for (int e = 0; e < 20; e++) begin
            tick();
            chk("held_busy", 32'(busy), (e == 8 || e == 17) ? 0 : 1);
        end
        start = 1'b0;

        n = 0;
        while (q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0_pending", q.size());
        end
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
